// File: rtl/pipelined_control_unit.sv
// Multi-cycle control unit: IDLE -> DEC -> [MEM] -> WB, with an absorbing HALT state.
// Define INSTR_COUNT_EN to build the 16-bit retired-instruction counter on retire_cnt.
module pipelined_control_unit #(
    parameter int INSTR_W = 10,
    parameter int REG_W   = 3,
    parameter int DATA_W  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               mem_ack,
    output logic [REG_W-1:0]   read_reg1,
    output logic [REG_W-1:0]   read_reg2,
    output logic [REG_W-1:0]   wr_reg,
    output logic               wr_en,
    output logic [1:0]         writeval_op,
    output logic [1:0]         alu_op,
    output logic [1:0]         fetch_op,
    output logic               jump_control,
    output logic [1:0]         ldst_en,
    output logic [DATA_W-1:0]  imm_val,
    output logic [DATA_W-1:0]  jmp_addr,
    output logic               instr_done,
    output logic               done,
    output logic [15:0]        retire_cnt
);

    localparam int IMM_W = INSTR_W - 2;
    localparam int JMP_W = 2 * REG_W;

    typedef enum logic [2:0] {IDLE, DEC, MEM, WB, HALT} state_t;

    state_t state_reg, state_next;

    logic [INSTR_W-1:0] instr_reg;
    logic [REG_W-1:0]   dst_reg, dst_next;
    logic [REG_W-1:0]   rs_reg, rt_reg;
    logic [1:0]         alu_reg, alu_next;
    logic [1:0]         wval_reg, wval_next;
    logic [1:0]         fetch_reg, fetch_next;
    logic [1:0]         ldst_reg, ldst_next;
    logic               jump_reg, jump_next;
    logic               wen_reg, wen_next;
    logic               halt_pulse_reg;
    logic [DATA_W-1:0]  imm_reg, jaddr_reg;
    logic [DATA_W-1:0]  imm_ext, jaddr_ext;

    logic [1:0]         op, fn;
    logic [REG_W-1:0]   rs, rt;

    assign op = instr_reg[INSTR_W-1:INSTR_W-2];
    assign fn = instr_reg[INSTR_W-3:INSTR_W-4];
    assign rs = instr_reg[2*REG_W-1:REG_W];
    assign rt = instr_reg[REG_W-1:0];

    // Each extended bit copies its source bit, or the field's top bit once past the field.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_sext
            localparam int IMM_IDX = (gi < IMM_W) ? gi : IMM_W - 1;
            localparam int JMP_IDX = (gi < JMP_W) ? gi : JMP_W - 1;
            assign imm_ext[gi]   = instr_reg[IMM_IDX];
            assign jaddr_ext[gi] = instr_reg[JMP_IDX];
        end
    endgenerate

    always_comb begin
        dst_next   = '0;
        alu_next   = 2'd0;
        wval_next  = 2'd0;
        fetch_next = 2'd0;
        ldst_next  = 2'd0;
        jump_next  = 1'b0;
        wen_next   = 1'b0;
        case (op)
            2'd0: begin
                dst_next = REG_W'(4);
                alu_next = fn;
                wen_next = 1'b1;
            end
            2'd1: begin
                case (fn)
                    2'd0: begin
                        dst_next  = rs;
                        wval_next = 2'd3;
                        wen_next  = 1'b1;
                    end
                    2'd1: begin
                        dst_next  = REG_W'(5);
                        ldst_next = 2'b10;
                        wen_next  = 1'b1;
                    end
                    2'd2:    ldst_next  = 2'b11;
                    default: fetch_next = 2'd2;
                endcase
            end
            2'd2: begin
                dst_next  = REG_W'(5);
                wval_next = 2'd2;
                wen_next  = 1'b1;
            end
            default: begin
                case (fn)
                    2'd0: begin
                        fetch_next = 2'd1;
                        jump_next  = 1'b1;
                    end
                    2'd1: fetch_next = 2'd1;
                    2'd2: begin
                        fetch_next = 2'd1;
                        jump_next  = 1'b1;
                        dst_next   = REG_W'(6);
                        wval_next  = 2'd1;
                        wen_next   = 1'b1;
                    end
                    default: fetch_next = 2'd3;
                endcase
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (instr_valid) state_next = DEC;
            DEC: begin
                if (op == 2'd1 && (fn == 2'd1 || fn == 2'd2))
                    state_next = MEM;
                else if (op == 2'd3 && fn == 2'd3)
                    state_next = HALT;
                else
                    state_next = WB;
            end
            MEM:     if (mem_ack) state_next = WB;
            WB:      state_next = IDLE;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            instr_reg      <= '0;
            dst_reg        <= '0;
            rs_reg         <= '0;
            rt_reg         <= '0;
            alu_reg        <= 2'd0;
            wval_reg       <= 2'd0;
            fetch_reg      <= 2'd0;
            ldst_reg       <= 2'd0;
            jump_reg       <= 1'b0;
            wen_reg        <= 1'b0;
            imm_reg        <= '0;
            jaddr_reg      <= '0;
            halt_pulse_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            halt_pulse_reg <= (state_reg == DEC) && (state_next == HALT);
            if (state_reg == IDLE && instr_valid)
                instr_reg <= instr;
            if (state_reg == DEC) begin
                dst_reg   <= dst_next;
                rs_reg    <= rs;
                rt_reg    <= rt;
                alu_reg   <= alu_next;
                wval_reg  <= wval_next;
                fetch_reg <= fetch_next;
                ldst_reg  <= ldst_next;
                jump_reg  <= jump_next;
                wen_reg   <= wen_next;
                imm_reg   <= imm_ext;
                jaddr_reg <= jaddr_ext;
            end
        end
    end

    // The halt pulse reuses the WB strobe path; its decoded fetch_reg is already 3.
    assign instr_ready  = (state_reg == IDLE);
    assign instr_done   = (state_reg == WB) || halt_pulse_reg;
    assign wr_en        = (state_reg == WB) && wen_reg;
    assign jump_control = (state_reg == WB) && jump_reg;
    assign fetch_op     = instr_done ? fetch_reg : 2'd0;
    assign ldst_en      = (state_reg == MEM) ? ldst_reg : 2'd0;
    assign done         = (state_reg == HALT);
    assign wr_reg       = dst_reg;
    assign read_reg1    = rs_reg;
    assign read_reg2    = rt_reg;
    assign alu_op       = alu_reg;
    assign writeval_op  = wval_reg;
    assign imm_val      = imm_reg;
    assign jmp_addr     = jaddr_reg;

`ifdef INSTR_COUNT_EN
    logic [15:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_reg <= 16'd0;
        else if (instr_done)
            cnt_reg <= cnt_reg + 16'd1;
    end

    assign retire_cnt = cnt_reg;
`else
    assign retire_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed table, random instructions vs a decode-rule model,
// and hand sequences for reset-in-MEM and HALT.
module tb_pipelined_control_unit;

    logic        clk;
    logic        rst_n;
    logic [9:0]  instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_ack;
    logic [2:0]  read_reg1, read_reg2, wr_reg;
    logic        wr_en;
    logic [1:0]  writeval_op, alu_op, fetch_op, ldst_en;
    logic        jump_control;
    logic [9:0]  imm_val, jmp_addr;
    logic        instr_done, done;
    logic [15:0] retire_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

`ifdef INSTR_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic [9:0] ins;
        int         ack;
        bit         wr;
        logic [2:0] wreg;
        bit         c_alu;
        logic [1:0] alu;
        bit         c_wv;
        logic [1:0] wv;
        logic [1:0] fetch;
        bit         jump;
        logic [1:0] ldst;
        logic [9:0] imm;
        logic [9:0] jaddr;
        logic [2:0] rs;
        logic [2:0] rt;
    } vec_t;

    vec_t vecs[10];

    pipelined_control_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .mem_ack      (mem_ack),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .wr_reg       (wr_reg),
        .wr_en        (wr_en),
        .writeval_op  (writeval_op),
        .alu_op       (alu_op),
        .fetch_op     (fetch_op),
        .jump_control (jump_control),
        .ldst_en      (ldst_en),
        .imm_val      (imm_val),
        .jmp_addr     (jmp_addr),
        .instr_done   (instr_done),
        .done         (done),
        .retire_cnt   (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] cnt_exp();
        return CNT_ON ? exp_cnt[15:0] : 16'd0;
    endfunction

    // Reference decode built directly from the instruction-set rules.
    function automatic vec_t model(input logic [9:0] ins, input int ack);
        vec_t v;
        int iv;
        int jv;
        logic [1:0] op;
        logic [1:0] fn;
        v = '{default: 0};
        op = ins[9:8];
        fn = ins[7:6];
        v.ins = ins;
        v.ack = ack;
        iv = int'(ins[7:0]);
        if (iv > 127) iv -= 256;
        jv = int'(ins[5:0]);
        if (jv > 31) jv -= 64;
        v.imm   = iv[9:0];
        v.jaddr = jv[9:0];
        v.rs    = ins[5:3];
        v.rt    = ins[2:0];
        case (op)
            2'd0: begin v.wr = 1; v.wreg = 3'd4; v.c_alu = 1; v.alu = fn; v.c_wv = 1; v.wv = 2'd0; end
            2'd1: begin
                case (fn)
                    2'd0: begin v.wr = 1; v.wreg = ins[5:3]; v.c_wv = 1; v.wv = 2'd3; end
                    2'd1: begin v.wr = 1; v.wreg = 3'd5; v.ldst = 2'b10; end
                    2'd2: v.ldst = 2'b11;
                    default: v.fetch = 2'd2;
                endcase
            end
            2'd2: begin v.wr = 1; v.wreg = 3'd5; v.c_wv = 1; v.wv = 2'd2; end
            default: begin
                case (fn)
                    2'd0: begin v.fetch = 2'd1; v.jump = 1; end
                    2'd1: v.fetch = 2'd1;
                    default: begin
                        v.fetch = 2'd1; v.jump = 1; v.wr = 1; v.wreg = 3'd6;
                        v.c_wv = 1; v.wv = 2'd1;
                    end
                endcase
            end
        endcase
        return v;
    endfunction

    // Runs one non-halting instruction from IDLE back to IDLE, checking every cycle.
    task automatic run_vec(input vec_t v, input bit junk_ack);
        chk("ready_idle", instr_ready, 1);
        instr = v.ins;
        instr_valid = 1'b1;
        mem_ack = 1'b0;
        step();
        instr_valid = 1'b0;
        instr = 10'($urandom);
        mem_ack = junk_ack;
        chk("ready_dec", instr_ready, 0);
        chk("done_dec", instr_done, 0);
        chk("wr_en_dec", wr_en, 0);
        chk("ldst_dec", ldst_en, 0);
        step();
        if (v.ldst != 2'd0) begin
            for (int k = 0; k <= v.ack; k++) begin
                chk("ldst_mem", ldst_en, v.ldst);
                chk("done_mem", instr_done, 0);
                chk("wr_en_mem", wr_en, 0);
                mem_ack = (k == v.ack);
                step();
            end
        end
        mem_ack = junk_ack;
        chk("wb_done", instr_done, 1);
        chk("wb_wr_en", wr_en, v.wr);
        if (v.wr) chk("wb_wr_reg", wr_reg, v.wreg);
        if (v.c_alu) chk("wb_alu_op", alu_op, v.alu);
        if (v.c_wv) chk("wb_writeval_op", writeval_op, v.wv);
        chk("wb_fetch_op", fetch_op, v.fetch);
        chk("wb_jump", jump_control, v.jump);
        chk("wb_ldst", ldst_en, 0);
        chk("wb_imm", imm_val, v.imm);
        chk("wb_jmp_addr", jmp_addr, v.jaddr);
        chk("wb_rs", read_reg1, v.rs);
        chk("wb_rt", read_reg2, v.rt);
        chk("wb_retire_cnt", retire_cnt, cnt_exp());
        step();
        exp_cnt++;
        mem_ack = 1'b0;
        chk("post_ready", instr_ready, 1);
        chk("post_done", instr_done, 0);
        chk("post_wr_en", wr_en, 0);
        chk("post_fetch", fetch_op, 0);
        chk("post_jump", jump_control, 0);
        chk("post_imm_hold", imm_val, v.imm);
        chk("post_jaddr_hold", jmp_addr, v.jaddr);
        if (v.wr) chk("post_wr_reg_hold", wr_reg, v.wreg);
        chk("post_retire_cnt", retire_cnt, cnt_exp());
        $display("txn instr=%b ack=%0d wr_en_exp=%0d wr_reg_exp=%0d fetch_exp=%0d checks=%0d",
                 v.ins, v.ack, v.wr, v.wreg, v.fetch, checks);
    endtask

    initial begin
        vec_t v;
        logic [9:0] ins;

        vecs[0] = '{10'b00_01_000_000, 0, 1, 3'd4, 1, 2'd1, 1, 2'd0, 2'd0, 0, 2'd0, 10'h040, 10'h000, 3'd0, 3'd0};
        vecs[1] = '{10'b10_11111111, 0, 1, 3'd5, 0, 2'd0, 1, 2'd2, 2'd0, 0, 2'd0, 10'h3FF, 10'h3FF, 3'd7, 3'd7};
        vecs[2] = '{10'b01_01_000_000, 3, 1, 3'd5, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'b10, 10'h040, 10'h000, 3'd0, 3'd0};
        vecs[3] = '{10'b11_10_100_000, 0, 1, 3'd6, 0, 2'd0, 1, 2'd1, 2'd1, 1, 2'd0, 10'h3A0, 10'h3E0, 3'd4, 3'd0};
        vecs[4] = '{10'b01_00_011_101, 0, 1, 3'd3, 0, 2'd0, 1, 2'd3, 2'd0, 0, 2'd0, 10'h01D, 10'h01D, 3'd3, 3'd5};
        vecs[5] = '{10'b01_10_010_110, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'b11, 10'h396, 10'h016, 3'd2, 3'd6};
        vecs[6] = '{10'b01_11_001_001, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 2'd2, 0, 2'd0, 10'h3C9, 10'h009, 3'd1, 3'd1};
        vecs[7] = '{10'b11_00_111_000, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 2'd1, 1, 2'd0, 10'h038, 10'h3F8, 3'd7, 3'd0};
        vecs[8] = '{10'b11_01_000_111, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 2'd1, 0, 2'd0, 10'h047, 10'h007, 3'd0, 3'd7};
        vecs[9] = '{10'b00_11_110_010, 2, 1, 3'd4, 1, 2'd3, 1, 2'd0, 2'd0, 0, 2'd0, 10'h3F2, 10'h3F2, 3'd6, 3'd2};

        rst_n = 1'b0;
        instr = 10'd0;
        instr_valid = 1'b0;
        mem_ack = 1'b0;
        repeat (2) step();
        chk("rst_ready", instr_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_instr_done", instr_done, 0);
        chk("rst_ldst", ldst_en, 0);
        chk("rst_fetch", fetch_op, 0);
        chk("rst_jump", jump_control, 0);
        chk("rst_wr_reg", wr_reg, 0);
        chk("rst_alu", alu_op, 0);
        chk("rst_wv", writeval_op, 0);
        chk("rst_imm", imm_val, 0);
        chk("rst_jaddr", jmp_addr, 0);
        chk("rst_rr1", read_reg1, 0);
        chk("rst_rr2", read_reg2, 0);
        chk("rst_retire_cnt", retire_cnt, 0);
        rst_n = 1'b1;
        exp_cnt = 0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i[0]);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                instr_valid = 1'b0;
                mem_ack = 1'($urandom);
                step();
                chk("gap_ready", instr_ready, 1);
                chk("gap_done", instr_done, 0);
            end
            ins = 10'($urandom);
            if (ins[9:6] == 4'b1111) ins[6] = 1'b0;
            v = model(ins, int'($urandom_range(0, 4)));
            run_vec(v, 1'($urandom));
        end

        // Reset arriving while a load waits for its acknowledge.
        instr = 10'b01_01_000_000;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        chk("mid_mem_ldst", ldst_en, 2'b10);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_cnt = 0;
        chk("rstmem_ldst", ldst_en, 0);
        chk("rstmem_done", instr_done, 0);
        chk("rstmem_ready", instr_ready, 1);
        chk("rstmem_wr_en", wr_en, 0);
        chk("rstmem_retire_cnt", retire_cnt, 0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("stray_ack_ready", instr_ready, 1);
        chk("stray_ack_wr_en", wr_en, 0);
        $display("txn reset-in-MEM checks=%0d", checks);

        run_vec(model(10'b00_10_001_010, 0), 1'b0);

        // Halt: one retire pulse, then absorbing until reset.
        instr = 10'b11_11_000_000;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("halt_dec_done", done, 0);
        step();
        chk("halt_done", done, 1);
        chk("halt_pulse", instr_done, 1);
        chk("halt_fetch", fetch_op, 3);
        chk("halt_wr_en", wr_en, 0);
        chk("halt_ready", instr_ready, 0);
        chk("halt_retire_cnt", retire_cnt, cnt_exp());
        step();
        exp_cnt++;
        chk("halt2_pulse", instr_done, 0);
        chk("halt2_fetch", fetch_op, 0);
        chk("halt2_done", done, 1);
        chk("halt2_retire_cnt", retire_cnt, cnt_exp());
        for (int i = 0; i < 4; i++) begin
            instr = 10'($urandom);
            instr_valid = 1'b1;
            mem_ack = 1'($urandom);
            step();
            chk("halt_hold_ready", instr_ready, 0);
            chk("halt_hold_done", done, 1);
            chk("halt_hold_pulse", instr_done, 0);
        end
        instr_valid = 1'b0;
        mem_ack = 1'b0;
        rst_n = 1'b0;
        step();
        chk("halt_rst_done", done, 0);
        chk("halt_rst_ready", instr_ready, 1);
        rst_n = 1'b1;
        step();
        chk("after_halt_ready", instr_ready, 1);
        chk("after_halt_retire_cnt", retire_cnt, 0);
        $display("txn halt-then-reset checks=%0d", checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 Parameter INSTR_W, default 10: instruction width; SHALL satisfy INSTR_W >= 4 + 2*REG_W.
REQ-002 Parameter REG_W, default 3: register-select width.
REQ-003 Parameter DATA_W, default 10: width of imm_val and jmp_addr.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port instr, input, INSTR_W: instruction word. op = instr[INSTR_W-1:INSTR_W-2], fn = instr[INSTR_W-3:INSTR_W-4], rs = instr[2*REG_W-1:REG_W], rt = instr[REG_W-1:0].
REQ-007 Port instr_valid, input, 1: instr holds a valid word.
REQ-008 Port instr_ready, output, 1: unit accepts instr this cycle.
REQ-009 Port mem_ack, input, 1: data memory has completed the load or store.
REQ-010 Ports read_reg1 and read_reg2, outputs, REG_W: registered rs and rt.
REQ-011 Ports wr_reg, output, REG_W; wr_en, output, 1; writeval_op, output, 2: register-file write controls.
REQ-012 Ports alu_op, output, 2; fetch_op, output, 2; jump_control, output, 1; ldst_en, output, 2: datapath controls.
REQ-013 Ports imm_val and jmp_addr, outputs, DATA_W: sign-extended instr[INSTR_W-3:0] and instr[2*REG_W-1:0].
REQ-014 Port instr_done, output, 1: one-cycle pulse when an instruction retires.
REQ-015 Port done, output, 1: sticky halt flag.
REQ-016 Port retire_cnt, output, 16: count of retired instructions (see REQ-031).

Function
REQ-017 The FSM SHALL have the states IDLE, DEC, MEM, WB and HALT, held in a registered state variable.
REQ-018 instr_ready SHALL equal 1 only in IDLE; in IDLE, a cycle with instr_valid=1 captures instr into an internal register, and the next state is DEC.
REQ-019 In DEC, all decoded fields SHALL be registered per REQ-020; the next state is MEM for op=1 with fn=1 or fn=2, HALT for op=3 with fn=3, and WB otherwise.
REQ-020 The decode table SHALL be:
- op0: wr_reg=4, alu_op=fn, writeval_op=0.
- op1 fn0: wr_reg=rs, writeval_op=3.
- op1 fn1: wr_reg=5, ldst_en=2'b10.
- op1 fn2: ldst_en=2'b11, no write.
- op1 fn3: fetch_op=2, no write.
- op2: wr_reg=5, writeval_op=2.
- op3 fn0: fetch_op=1, jump_control=1.
- op3 fn1: fetch_op=1.
- op3 fn2: fetch_op=1, jump_control=1, wr_reg=6, writeval_op=1.
- op3 fn3: fetch_op=3, done=1.
REQ-021 ldst_en SHALL be nonzero only while in MEM; MEM SHALL hold until the first cycle with mem_ack=1, then go to WB.
REQ-022 mem_ack SHALL be ignored outside MEM.
REQ-023 In WB, for exactly one cycle: wr_en SHALL be 1 only for instructions that write per REQ-020; fetch_op and jump_control SHALL show their decoded values; instr_done SHALL be 1. The next state is IDLE.
REQ-024 Outside WB, wr_en, fetch_op, jump_control and instr_done SHALL be 0; alu_op, wr_reg, writeval_op, imm_val, jmp_addr, read_reg1 and read_reg2 SHALL hold their last decoded values.
REQ-025 Latency: for an instruction accepted at edge T, a non-memory instruction is in WB at cycle T+2 and instr_ready=1 again at T+3; a memory instruction is in WB one cycle after mem_ack.
REQ-026 Entering HALT SHALL set done=1, pulse instr_done for one cycle and drive fetch_op=3 for that cycle.
REQ-027 HALT SHALL be absorbing: instr_ready=0 and all inputs ignored until reset.
REQ-028 Sign extension SHALL replicate the top bit of each source field to DATA_W bits.

Reset
REQ-029 When rst_n=0 at a clock edge, the next state SHALL be IDLE from any state, including mid-MEM, and the in-flight instruction SHALL be discarded.
REQ-030 After reset, every output SHALL be 0 except instr_ready, which is 1; retire_cnt is also 0.

Configuration
REQ-031 When the macro INSTR_COUNT_EN is defined, retire_cnt SHALL increment by 1 on every instr_done pulse and wrap from 16'hFFFF to 0; when it is undefined, retire_cnt SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-032 Reset, then instr=10'b00_01_000_000 with instr_valid=1 for one cycle -> at T+2: wr_en=1, wr_reg=4, alu_op=1 and instr_done=1; at T+3: instr_ready=1.
REQ-033 instr=10'b10_11111111 -> in WB: imm_val=10'h3FF, wr_reg=5, writeval_op=2 and wr_en=1.
REQ-034 Load 10'b01_01_000_000, holding mem_ack=0 for 3 cycles -> ldst_en=2'b10 for 4 cycles; after mem_ack=1, the next cycle shows wr_en=1 and wr_reg=5.
REQ-035 Jal 10'b11_10_100_000 -> in WB: jump_control=1, fetch_op=1, wr_reg=6, writeval_op=1 and jmp_addr=10'h3E0.
REQ-036 Halt 10'b11_11_000_000 -> done=1 stays high; instr_ready stays 0 with further instr_valid pulses; rst_n=0 clears done.
REQ-037 Assert rst_n=0 while in MEM -> next cycle: state IDLE, ldst_en=0, no instr_done. With INSTR_COUNT_EN defined, 65537 retirements -> retire_cnt=1.
